// File: rtl/kronos_wb_sched_pkg.sv
// kronos_wb_sched_pkg: shared types for the write-back scheduler (package kronos_types)
package kronos_types;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } wb_req_t;
endpackage

// File: rtl/kronos_wb_sched_if.sv
// kronos_wb_sched_if: claim/check, write-back handshakes and regfile write port; KRONOS_WB_BYPASS_EN adds fwd_*
interface kronos_wb_sched_if;
  logic        claim_vld;
  logic [4:0]  claim_rd;
  logic        claim_rdy;
  logic [4:0]  chk_rs1;
  logic        chk_rs1_en;
  logic [4:0]  chk_rs2;
  logic        chk_rs2_en;
  logic        hazard;
  logic        wb0_vld;
  logic        wb0_rdy;
  logic [4:0]  wb0_sel;
  logic [31:0] wb0_data;
  logic        wb1_vld;
  logic        wb1_rdy;
  logic [4:0]  wb1_sel;
  logic [31:0] wb1_data;
  logic        regwr_en;
  logic [4:0]  regwr_sel;
  logic [31:0] regwr_data;
`ifdef KRONOS_WB_BYPASS_EN
  logic        fwd_rs1_vld;
  logic        fwd_rs2_vld;
  logic [31:0] fwd_data;
  modport master (
    output claim_vld, claim_rd, chk_rs1, chk_rs1_en, chk_rs2, chk_rs2_en,
    output wb0_vld, wb0_sel, wb0_data, wb1_vld, wb1_sel, wb1_data,
    input  claim_rdy, hazard, wb0_rdy, wb1_rdy, regwr_en, regwr_sel, regwr_data,
    input  fwd_rs1_vld, fwd_rs2_vld, fwd_data
  );
  modport slave (
    input  claim_vld, claim_rd, chk_rs1, chk_rs1_en, chk_rs2, chk_rs2_en,
    input  wb0_vld, wb0_sel, wb0_data, wb1_vld, wb1_sel, wb1_data,
    output claim_rdy, hazard, wb0_rdy, wb1_rdy, regwr_en, regwr_sel, regwr_data,
    output fwd_rs1_vld, fwd_rs2_vld, fwd_data
  );
`else
  modport master (
    output claim_vld, claim_rd, chk_rs1, chk_rs1_en, chk_rs2, chk_rs2_en,
    output wb0_vld, wb0_sel, wb0_data, wb1_vld, wb1_sel, wb1_data,
    input  claim_rdy, hazard, wb0_rdy, wb1_rdy, regwr_en, regwr_sel, regwr_data
  );
  modport slave (
    input  claim_vld, claim_rd, chk_rs1, chk_rs1_en, chk_rs2, chk_rs2_en,
    input  wb0_vld, wb0_sel, wb0_data, wb1_vld, wb1_sel, wb1_data,
    output claim_rdy, hazard, wb0_rdy, wb1_rdy, regwr_en, regwr_sel, regwr_data
  );
`endif
endinterface

// File: rtl/kronos_wb_sched_arb.sv
// kronos_wb_arb: two-way arbiter, wb1 preferred, wb0 forced through after STARVE_LIMIT wb1 wins
module kronos_wb_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic vld0,
  input  logic vld1,
  output logic gnt0,
  output logic gnt1
);
  localparam int W = $clog2(STARVE_LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(STARVE_LIMIT);
  logic [W-1:0] starve;
  always_comb begin
    gnt0 = vld0 & (~vld1 | (starve == LIM));
    gnt1 = vld1 & ~gnt0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve <= '0;
    else if (!vld0 || gnt0) starve <= '0;
    else if (gnt1 && starve != LIM) starve <= starve + 1'b1;
  end
endmodule

// File: rtl/kronos_wb_sched.sv
// kronos_wb_sched: regfile write-port scheduler with destination scoreboard and RAW hazard detect
// KRONOS_WB_BYPASS_EN: forward the registered write to ID and suppress the matching hazard
module kronos_wb_sched
  import kronos_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  kronos_wb_sched_if.slave bus
);
  logic                gnt0, gnt1, claim_fire;
  logic [NUM_REGS-1:0] busy, busy_n;
  wb_req_t             req0, req1, win;
  logic                en;
  logic [4:0]          sel;
  logic [31:0]         data;
  kronos_wb_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk(clk), .rst(rst), .vld0(bus.wb0_vld), .vld1(bus.wb1_vld), .gnt0(gnt0), .gnt1(gnt1)
  );
  assign req0 = '{sel: bus.wb0_sel, data: bus.wb0_data};
  assign req1 = '{sel: bus.wb1_sel, data: bus.wb1_data};
  assign win = gnt1 ? req1 : req0;
  assign bus.wb0_rdy = gnt0;
  assign bus.wb1_rdy = gnt1;
  assign bus.claim_rdy = ~busy[bus.claim_rd] | (bus.claim_rd == 5'd0);
  assign claim_fire = bus.claim_vld & bus.claim_rdy & (bus.claim_rd != 5'd0);
  // clear applied before set so a same-edge reclaim keeps the register busy
  always_comb begin
    busy_n = busy;
    if (en) busy_n[sel] = 1'b0;
    if (claim_fire) busy_n[bus.claim_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      en   <= 1'b0;
      sel  <= '0;
      data <= '0;
    end else begin
      busy <= busy_n;
      en   <= (gnt0 | gnt1) & (win.sel != 5'd0);
      if ((gnt0 | gnt1) && win.sel != 5'd0) begin
        sel  <= win.sel;
        data <= win.data;
      end
    end
  end
  assign bus.regwr_en   = en;
  assign bus.regwr_sel  = sel;
  assign bus.regwr_data = data;
`ifdef KRONOS_WB_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = en & bus.chk_rs1_en & (sel == bus.chk_rs1) & (bus.chk_rs1 != 5'd0);
  assign fwd2 = en & bus.chk_rs2_en & (sel == bus.chk_rs2) & (bus.chk_rs2 != 5'd0);
  assign bus.fwd_rs1_vld = fwd1;
  assign bus.fwd_rs2_vld = fwd2;
  assign bus.fwd_data    = data;
  assign bus.hazard = (bus.chk_rs1_en & busy[bus.chk_rs1] & ~fwd1) |
                      (bus.chk_rs2_en & busy[bus.chk_rs2] & ~fwd2);
`else
  assign bus.hazard = (bus.chk_rs1_en & busy[bus.chk_rs1]) |
                      (bus.chk_rs2_en & busy[bus.chk_rs2]);
`endif
endmodule
